// File: rtl/regfile_wb_pkg.sv
// Shared widths and constants for the architectural register file.
// Provides RegAddrBus/RegBus widths, ZeroWorld, RstEnable, True/False and REG_NUM.
// Imported by regfile_wb and regfile_scoreboard.
package regfile_wb_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int REG_NUM    = 32;

  localparam logic [RegBus-1:0] ZeroWorld = '0;
  localparam logic              RstEnable = 1'b1;
  localparam logic              True      = 1'b1;
  localparam logic              False     = 1'b0;

  typedef logic [RegAddrBus-1:0] reg_addr_t;
  typedef logic [RegBus-1:0]     reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters, sticky overflow flag and hazard lookup for two query ports.
// Latency: counters update on posedge; hazard_stall is combinational from query address and counters.
// Backpressure: rdy_in=0 freezes counters and overflow; hazard_stall still reflects current state.
// Ports: clk_in/rst_in/rdy_in, wb_if_write/wb_reg_addr (retire), issue_en/issue_rd (allocate),
//        q0_*/q1_* (ID read queries), hazard_stall, sb_overflow.
// Macro REGFILE_BYPASS_EN: a counter of 1 retiring this cycle is not hazardous.
module regfile_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int REG_NUM = regfile_wb_pkg::REG_NUM,
  parameter int CNT_W   = 2
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      wb_if_write,
  input  reg_addr_t wb_reg_addr,
  input  logic      issue_en,
  input  reg_addr_t issue_rd,
  input  logic      q0_en,
  input  reg_addr_t q0_addr,
  input  logic      q1_en,
  input  reg_addr_t q1_addr,
  output logic      hazard_stall,
  output logic      sb_overflow
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0]   cnt [REG_NUM];
  logic               wb_act;
  logic               iss_act;
  logic [REG_NUM-1:0] wb_sel;
  logic [REG_NUM-1:0] iss_sel;

  assign wb_act  = rdy_in && wb_if_write && (wb_reg_addr != '0);
  assign iss_act = rdy_in && issue_en && (issue_rd != '0);
  assign wb_sel  = wb_act  ? (REG_NUM'(1) << wb_reg_addr) : '0;
  assign iss_sel = iss_act ? (REG_NUM'(1) << issue_rd)    : '0;

  // x0 is never selected, so cnt[0] stays at its reset value of zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
      sb_overflow <= False;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (iss_sel[i] && !wb_sel[i]) begin
          if (cnt[i] == CntMax) sb_overflow <= True;  // saturate, flag sticky error
          else                  cnt[i] <= cnt[i] + CntOne;
        end else if (wb_sel[i] && !iss_sel[i]) begin
          // Retiring a write nobody is tracking (e.g. in flight across reset) is legal.
          if (cnt[i] != '0) cnt[i] <= cnt[i] - CntOne;
        end
      end
    end
  end

  function automatic logic hazard_of(input logic en, input reg_addr_t a);
    logic hz;
    hz = en && (a != '0) && (cnt[a] != '0);
`ifdef REGFILE_BYPASS_EN
    // The last outstanding write lands this cycle and is forwarded to the read.
    if (wb_act && (wb_reg_addr == a) && (cnt[a] == CntOne)) hz = False;
`endif
    return hz;
  endfunction

  assign hazard_stall = hazard_of(q0_en, q0_addr) || hazard_of(q1_en, q1_addr);

endmodule

// File: rtl/regfile_wb.sv
// RV32I architectural register file: writeback port from MEM/WB, two combinational read ports, pending scoreboard.
// Latency: reads 0 cycles; writes visible the cycle after their posedge; hazard_stall combinational.
// Backpressure: rdy_in=0 blocks writes and counter updates; hazard_stall asks the stall controller to hold ID.
// Ports: clk_in, rst_in (async active-high), rdy_in, wb_if_write/wb_reg_addr/wb_reg_data,
//        rs1_read_en/rs1_addr/rs1_data, rs2_read_en/rs2_addr/rs2_data, issue_en/issue_rd,
//        hazard_stall, sb_overflow.
// Macro REGFILE_BYPASS_EN: forward same-cycle writeback data to the read ports.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int REG_NUM = regfile_wb_pkg::REG_NUM,
  parameter int CNT_W   = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  wb_if_write,
  input  logic [RegAddrBus-1:0] wb_reg_addr,
  input  logic [RegBus-1:0]     wb_reg_data,
  input  logic                  rs1_read_en,
  input  logic [RegAddrBus-1:0] rs1_addr,
  output logic [RegBus-1:0]     rs1_data,
  input  logic                  rs2_read_en,
  input  logic [RegAddrBus-1:0] rs2_addr,
  output logic [RegBus-1:0]     rs2_data,
  input  logic                  issue_en,
  input  logic [RegAddrBus-1:0] issue_rd,
  output logic                  hazard_stall,
  output logic                  sb_overflow
);

  reg_data_t regs [REG_NUM];
  logic      wb_act;
  logic      sb_stall;

  assign wb_act = rdy_in && wb_if_write && (wb_reg_addr != '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= ZeroWorld;
    end else if (wb_act) begin
      regs[wb_reg_addr] <= wb_reg_data;
    end
  end

  function automatic reg_data_t read_port(input logic en, input reg_addr_t a);
    reg_data_t d;
    d = ZeroWorld;
    if (!rst_in && en && (a != '0)) begin
      d = regs[a];
`ifdef REGFILE_BYPASS_EN
      if (wb_act && (wb_reg_addr == a)) d = wb_reg_data;
`endif
    end
    return d;
  endfunction

  assign rs1_data = read_port(rs1_read_en, rs1_addr);
  assign rs2_data = read_port(rs2_read_en, rs2_addr);

  regfile_scoreboard #(
    .REG_NUM (REG_NUM),
    .CNT_W   (CNT_W)
  ) u_sb (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .wb_if_write  (wb_if_write),
    .wb_reg_addr  (wb_reg_addr),
    .issue_en     (issue_en),
    .issue_rd     (issue_rd),
    .q0_en        (rs1_read_en),
    .q0_addr      (rs1_addr),
    .q1_en        (rs2_read_en),
    .q1_addr      (rs2_addr),
    .hazard_stall (sb_stall),
    .sb_overflow  (sb_overflow)
  );

  assign hazard_stall = sb_stall && !rst_in;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed, table-driven check of regfile_wb: one vector per cycle, outputs compared
// at the falling edge before the state-changing rising edge, plus an async-reset sequence.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        wb_if_write = 1'b0;
  logic [4:0]  wb_reg_addr = '0;
  logic [31:0] wb_reg_data = '0;
  logic        rs1_read_en = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [31:0] rs1_data;
  logic        rs2_read_en = 1'b0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs2_data;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        hazard_stall;
  logic        sb_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  regfile_wb dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .wb_if_write  (wb_if_write),
    .wb_reg_addr  (wb_reg_addr),
    .wb_reg_data  (wb_reg_data),
    .rs1_read_en  (rs1_read_en),
    .rs1_addr     (rs1_addr),
    .rs1_data     (rs1_data),
    .rs2_read_en  (rs2_read_en),
    .rs2_addr     (rs2_addr),
    .rs2_data     (rs2_data),
    .issue_en     (issue_en),
    .issue_rd     (issue_rd),
    .hazard_stall (hazard_stall),
    .sb_overflow  (sb_overflow)
  );

  typedef struct {
    logic        rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e1;
    logic [4:0]  a1;
    logic        e2;
    logic [4:0]  a2;
    logic        ie;
    logic [4:0]  ird;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        xs;
    logic        xo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic e1, logic [4:0] a1, logic e2, logic [4:0] a2,
                              logic ie, logic [4:0] ird,
                              logic [31:0] x1, logic [31:0] x2, logic xs, logic xo);
    vec_t v;
    v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd;
    v.e1 = e1; v.a1 = a1; v.e2 = e2; v.a2 = a2;
    v.ie = ie; v.ird = ird;
    v.x1 = x1; v.x2 = x2; v.xs = xs; v.xo = xo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy_in = v.rdy; wb_if_write = v.we; wb_reg_addr = v.wa; wb_reg_data = v.wd;
    rs1_read_en = v.e1; rs1_addr = v.a1; rs2_read_en = v.e2; rs2_addr = v.a2;
    issue_en = v.ie; issue_rd = v.ird;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] x1, input logic [31:0] x2,
                            input logic xs, input logic xo);
    chk({tag, "_rs1"}, rs1_data, x1);
    chk({tag, "_rs2"}, rs2_data, x2);
    chk({tag, "_stall"}, {31'b0, hazard_stall}, {31'b0, xs});
    chk({tag, "_ovf"}, {31'b0, sb_overflow}, {31'b0, xo});
  endtask

  function automatic vec_t idle_rd(logic e1, logic [4:0] a1, logic e2, logic [4:0] a2,
                                   logic [31:0] x1, logic [31:0] x2, logic xs, logic xo);
    return mk(1, 0, 0, 0, e1, a1, e2, a2, 0, 0, x1, x2, xs, xo);
  endfunction

  initial begin
    // rdy we wa wd | e1 a1 e2 a2 | ie ird | x1 x2 stall ovf
    vecs.push_back(idle_rd(1, 5, 1, 5, 0, 0, 0, 0));                                              // 0
    vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 0, 0, 0,
                      BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0));                                      // 1
    vecs.push_back(idle_rd(1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0));                        // 2
    vecs.push_back(mk(1, 1, 0, 32'h1234, 1, 0, 1, 5, 0, 0, 0, 32'hDEADBEEF, 0, 0));               // 3
    vecs.push_back(idle_rd(1, 0, 0, 5, 0, 0, 0, 0));                                              // 4
    vecs.push_back(mk(1, 0, 0, 0, 1, 7, 0, 0, 1, 7, 0, 0, 0, 0));                                 // 5
    vecs.push_back(idle_rd(1, 7, 0, 0, 0, 0, 1, 0));                                              // 6
    vecs.push_back(mk(1, 1, 7, 32'h55, 1, 7, 0, 0, 0, 0, BYP ? 32'h55 : 32'h0, 0, !BYP, 0));      // 7
    vecs.push_back(idle_rd(1, 7, 0, 0, 32'h55, 0, 0, 0));                                         // 8
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 0, 0));                                 // 9
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 1, 0));                                 // 10
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));                                 // 11
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, 1, 9, 0, 0, 1, 0));                                 // 12
    vecs.push_back(mk(1, 1, 9, 32'h99, 1, 9, 0, 0, 0, 0, BYP ? 32'h99 : 32'h0, 0, 1, 1));         // 13
    vecs.push_back(mk(1, 1, 9, 32'h9A, 1, 9, 0, 0, 0, 0, BYP ? 32'h9A : 32'h99, 0, 1, 1));        // 14
    vecs.push_back(mk(1, 1, 9, 32'h9B, 0, 0, 1, 9, 0, 0, 0, BYP ? 32'h9B : 32'h9A, !BYP, 1));     // 15
    vecs.push_back(idle_rd(1, 9, 1, 9, 32'h9B, 32'h9B, 0, 1));                                    // 16
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1));                                 // 17
    vecs.push_back(mk(1, 1, 3, 32'h33, 1, 3, 0, 0, 1, 3, BYP ? 32'h33 : 32'h0, 0, !BYP, 1));      // 18
    vecs.push_back(idle_rd(1, 3, 0, 0, 32'h33, 0, 1, 1));                                         // 19
    vecs.push_back(mk(0, 1, 3, 32'h44, 0, 0, 1, 3, 1, 4, 0, 32'h33, 1, 1));                       // 20
    vecs.push_back(idle_rd(1, 3, 0, 0, 32'h33, 0, 1, 1));                                         // 21
    vecs.push_back(idle_rd(0, 0, 1, 4, 0, 0, 0, 1));                                              // 22
    vecs.push_back(mk(1, 1, 3, 32'h66, 1, 3, 0, 0, 0, 0, BYP ? 32'h66 : 32'h33, 0, !BYP, 1));     // 23
    vecs.push_back(idle_rd(1, 3, 0, 0, 32'h66, 0, 0, 1));                                         // 24
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1));                                // 25
    vecs.push_back(idle_rd(0, 11, 1, 5, 0, 32'hDEADBEEF, 0, 1));                                  // 26
    vecs.push_back(idle_rd(1, 11, 0, 0, 0, 0, 1, 1));                                             // 27

    // Held in reset: outputs quiet even with reads enabled.
    rs1_read_en = 1'b1; rs1_addr = 5'd5; rs2_read_en = 1'b1; rs2_addr = 5'd5;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_outs("reset", 0, 0, 0, 0);
    rst_in = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk_in); #1;
      drive(vecs[i]);
      @(negedge clk_in);
      check_outs($sformatf("v%0d", i), vecs[i].x1, vecs[i].x2, vecs[i].xs, vecs[i].xo);
    end

    // Asynchronous reset mid-operation: x11 pending, overflow set, x5 holds data.
    @(posedge clk_in); #1;
    drive(idle_rd(1, 5, 1, 11, 32'hDEADBEEF, 0, 1, 1));
    #1;
    check_outs("pre_arst", 32'hDEADBEEF, 0, 1, 1);
    rst_in = 1'b1;
    #1;
    check_outs("arst", 0, 0, 0, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    // Late writeback to x11 arriving after reset: counter already 0.
    drive(mk(1, 1, 11, 32'h77, 1, 11, 1, 5, 0, 0, 0, 0, 0, 0));
    @(negedge clk_in);
    check_outs("post_arst", BYP ? 32'h77 : 32'h0, 0, 0, 0);
    @(posedge clk_in); #1;
    drive(idle_rd(1, 11, 1, 11, 32'h77, 32'h77, 0, 0));
    @(negedge clk_in);
    check_outs("post_arst_wb", 32'h77, 32'h77, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
